// File: rtl/skew_delay_line.sv
// -----------------------------------------------------------------------------
// skew_delay_line
//
// Multi-lane delay line with a runtime-programmable base depth and a valid bit
// per stage. Lane i is tapped at (depth - 1 + i*SKEW). Successive lanes
// therefore come out one SKEW step later than the previous lane. This is the
// diagonal skew a systolic array expects on its row and column inputs.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   shift_en     advance every lane by one stage (RUN state only)
//   din_valid    valid flag shifted in together with din
//   din          lane i at din[i*WIDTH +: WIDTH]
//   cfg_depth    requested base delay; cfg_load applies it (only when empty)
//   flush        clear every stored valid bit, keeping the data
//   drain        self-drain: shift zeros in until nothing valid remains
//   dout         lane i tap data, same packing as din
//   dout_valid   per-lane tap valid
//   busy         any stored valid bit set, including stages past the tap
//   drain_done   one-cycle pulse when a drain empties the line
//   cfg_err      one-cycle pulse when a cfg_load is rejected
// -----------------------------------------------------------------------------
module skew_delay_line #(
    parameter int WIDTH         = 8,
    parameter int LANES         = 4,
    parameter int MAX_DEPTH     = 32,
    parameter int SKEW          = 1,
    parameter int DEFAULT_DEPTH = 26,
    parameter int ZERO_INVALID  = 1,
    localparam int DW           = $clog2(MAX_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   shift_en,
    input  logic                   din_valid,
    input  logic [LANES*WIDTH-1:0] din,
    input  logic [DW-1:0]          cfg_depth,
    input  logic                   cfg_load,
    input  logic                   flush,
    input  logic                   drain,
    output logic [LANES*WIDTH-1:0] dout,
    output logic [LANES-1:0]       dout_valid,
    output logic                   busy,
    output logic                   drain_done,
    output logic                   cfg_err
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          drain_done_q, drain_done_d;
    logic          cfg_err_q, cfg_err_d;

    // Datapath controls produced by the control process.
    logic do_shift;
    logic do_flush;
    logic shift_zero;

    logic [LANES-1:0] lane_busy;
    logic [LANES-1:0] lane_busy_next;
    logic             busy_after_shift;

    // A request of 0 becomes 1 and anything above MAX_DEPTH saturates.
    function automatic logic [DW-1:0] clamp_depth(input logic [DW-1:0] req);
        if (req == '0) begin
            return DW'(1);
        end else if (req > DW'(MAX_DEPTH)) begin
            return DW'(MAX_DEPTH);
        end
        return req;
    endfunction

    // -------------------------------------------------------------------------
    // Control: flush > drain/state > cfg_load > shift
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block is given a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d      = state_q;
        depth_d      = depth_q;
        drain_done_d = 1'b0;
        cfg_err_d    = 1'b0;
        do_shift     = 1'b0;
        do_flush     = 1'b0;
        shift_zero   = 1'b0;

        if (flush) begin
            // Flush overrides any shift and cancels a drain without a done pulse.
            do_flush  = 1'b1;
            state_d   = ST_RUN;
            cfg_err_d = cfg_load;
        end else if (state_q == ST_DRAIN) begin
            // Self-drain ignores shift_en and pushes empty samples every cycle.
            do_shift   = 1'b1;
            shift_zero = 1'b1;
            cfg_err_d  = cfg_load;
            // The exit test looks at the occupancy after this cycle's shift.
            if (!busy_after_shift) begin
                state_d      = ST_RUN;
                drain_done_d = 1'b1;
            end
        end else begin
            if (drain) begin
                state_d   = ST_DRAIN;
                cfg_err_d = cfg_load;
            end else if (cfg_load) begin
                if (busy) begin
                    cfg_err_d = 1'b1;
                end else begin
                    depth_d = clamp_depth(cfg_depth);
                end
            end
            do_shift = shift_en;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // that every register samples the values from before the clock edge.
        if (rst) begin
            state_q      <= ST_RUN;
            depth_q      <= DW'(DEFAULT_DEPTH);
            drain_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            depth_q      <= depth_d;
            drain_done_q <= drain_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Per-lane storage: lane i holds MAX_DEPTH + i*SKEW stages, stage 0 = input
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int LEN = MAX_DEPTH + i * SKEW;
        localparam int OFS = i * SKEW;
        localparam int IW  = (LEN > 1) ? $clog2(LEN) : 1;

        logic [WIDTH-1:0] data_q [LEN];
        logic [LEN-1:0]   vld_q;
        logic [WIDTH-1:0] lane_in;
        logic             vld_in;
        logic [IW-1:0]    tap_idx;
        logic [WIDTH-1:0] tap_data;
        logic             tap_vld;

        assign lane_in = shift_zero ? '0 : din[i*WIDTH +: WIDTH];
        assign vld_in  = shift_zero ? 1'b0 : din_valid;

        always_ff @(posedge clk) begin
            // NOTE: the sample storage is reset too, because dout must read 0
            // straight after reset regardless of what was in flight.
            if (rst) begin
                for (int k = 0; k < LEN; k++) begin
                    data_q[k] <= '0;
                end
                vld_q <= '0;
            end else if (do_flush) begin
                vld_q <= '0;
            end else if (do_shift) begin
                data_q[0] <= lane_in;
                for (int k = 1; k < LEN; k++) begin
                    data_q[k] <= data_q[k-1];
                end
                vld_q <= (vld_q << 1) | LEN'(vld_in);
            end
        end

        // depth_q never exceeds MAX_DEPTH, so the tap stays inside this lane.
        assign tap_idx  = IW'(int'(depth_q) - 1 + OFS);
        assign tap_data = data_q[tap_idx];
        assign tap_vld  = vld_q[tap_idx];

        assign dout[i*WIDTH +: WIDTH] = (ZERO_INVALID != 0 && !tap_vld) ? '0 : tap_data;
        assign dout_valid[i]          = tap_vld;

        // Occupancy now, and occupancy once the last stage has been shifted out.
        assign lane_busy[i]      = |vld_q;
        assign lane_busy_next[i] = |(vld_q << 1);
    end

    assign busy_after_shift = |lane_busy_next;
    assign busy             = |lane_busy;
    assign drain_done       = drain_done_q;
    assign cfg_err          = cfg_err_q;

endmodule
